// File: rtl/p_ex_mem_stage.sv
// RV32IM execute stage with EX/MEM pipeline register: ALU, branch resolution, M-extension.
// Define RV32M_EXT_EN to build the multiplier and iterative divider; otherwise M ops return 0.
module p_ex_mem_stage #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DIV_CYCLES   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    i_flush,
  input  logic                    i_reg_write_en,
  input  logic                    i_mem_write_en,
  input  logic                    i_mem_read_en,
  input  logic                    i_alu_src_a,
  input  logic                    i_do_branch,
  input  logic                    i_do_jump,
  input  logic [1:0]              i_wb_sel,
  input  logic [1:0]              i_alu_src_b,
  input  logic                    i_is_muldiv,
  input  logic [WIDTH-1:0]        i_pc,
  input  logic [WIDTH-1:0]        i_pc_plus_4,
  input  logic [WIDTH-1:0]        i_rs1_data,
  input  logic [WIDTH-1:0]        i_rs2_data,
  input  logic [WIDTH-1:0]        i_imm,
  input  logic [4:0]              i_rd_addr,
  input  logic [2:0]              i_funct3,
  input  logic [6:0]              i_opcode,
  input  logic [ALU_OP_WIDTH-1:0] i_alu_op,
  output logic                    o_busy,
  output logic                    o_branch_taken,
  output logic [WIDTH-1:0]        o_branch_target,
  output logic [WIDTH-1:0]        o_result,
  output logic [WIDTH-1:0]        o_store_data,
  output logic [WIDTH-1:0]        o_pc_plus_4,
  output logic [4:0]              o_rd_addr,
  output logic [2:0]              o_funct3,
  output logic [1:0]              o_wb_sel,
  output logic                    o_reg_write_en,
  output logic                    o_mem_write_en,
  output logic                    o_mem_read_en
);

  localparam logic [ALU_OP_WIDTH-1:0] AluAdd  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] AluSub  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] AluSll  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] AluSlt  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] AluSltu = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] AluXor  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] AluSrl  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] AluSra  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] AluOr   = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] AluAnd  = ALU_OP_WIDTH'(9);
  localparam int unsigned CtlW = 2 * WIDTH + 13;

  logic [WIDTH-1:0] op_a, op_b, alu_res, mul_res, div_res;
  logic [4:0]       shamt;
  logic             br_cond, div_done;
  logic [CtlW-1:0]  hold_ctl;

  always_comb begin
    op_a = i_alu_src_a ? i_pc : i_rs1_data;
    case (i_alu_src_b)
      2'b00:   op_b = i_rs2_data;
      2'b10:   op_b = WIDTH'(4);
      default: op_b = i_imm;
    endcase
    shamt = op_b[4:0];
    case (i_alu_op)
      AluAdd:  alu_res = op_a + op_b;
      AluSub:  alu_res = op_a - op_b;
      AluSll:  alu_res = op_a << shamt;
      AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      AluSltu: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      AluXor:  alu_res = op_a ^ op_b;
      AluSrl:  alu_res = op_a >> shamt;
      AluSra:  alu_res = $unsigned($signed(op_a) >>> shamt);
      AluOr:   alu_res = op_a | op_b;
      AluAnd:  alu_res = op_a & op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (i_funct3)
      3'b000:  br_cond = (i_rs1_data == i_rs2_data);
      3'b001:  br_cond = (i_rs1_data != i_rs2_data);
      3'b100:  br_cond = $signed(i_rs1_data) < $signed(i_rs2_data);
      3'b101:  br_cond = $signed(i_rs1_data) >= $signed(i_rs2_data);
      3'b110:  br_cond = i_rs1_data < i_rs2_data;
      3'b111:  br_cond = i_rs1_data >= i_rs2_data;
      default: br_cond = 1'b0;
    endcase
    o_branch_target = (i_opcode == 7'b1100111) ?
                      ((i_rs1_data + i_imm) & {{(WIDTH-1){1'b1}}, 1'b0}) : (i_pc + i_imm);
    o_branch_taken  = ((i_do_branch & br_cond) | i_do_jump) & en & ~i_flush & ~o_busy;
  end

`ifdef RV32M_EXT_EN
  localparam int unsigned CntW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d, is_rem_q, is_rem_d;
  logic [CtlW-1:0]  hold_q, hold_d;
  logic             div_issue, a_neg, b_neg, mul_a_sgn, mul_b_sgn, rem_ge;
  logic [WIDTH-1:0] a_mag, b_mag, rem_sub;
  logic [WIDTH:0]   rem_sh;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;

  // Operands sign- or zero-extended to 2*WIDTH so one unsigned product covers all MUL forms
  always_comb begin
    mul_a_sgn = (i_funct3[1:0] == 2'b01) | (i_funct3[1:0] == 2'b10);
    mul_b_sgn = (i_funct3[1:0] == 2'b01);
    mul_a     = {{WIDTH{mul_a_sgn & i_rs1_data[WIDTH-1]}}, i_rs1_data};
    mul_b     = {{WIDTH{mul_b_sgn & i_rs2_data[WIDTH-1]}}, i_rs2_data};
    prod      = mul_a * mul_b;
    mul_res   = (i_funct3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  assign div_issue = (state_q == StIdle) & en & i_is_muldiv & i_funct3[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (en | i_flush) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = StIdle;
    end else if (en) begin
      case (state_q)
        StIdle:  if (div_issue) state_d = StBusy;
        StBusy:  if (cnt_q == CntLast) state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_busy   = div_issue | (state_q == StBusy);
    div_done = (state_q == StDone);
  end

  always_comb begin
    a_neg   = ~i_funct3[0] & i_rs1_data[WIDTH-1];
    b_neg   = ~i_funct3[0] & i_rs2_data[WIDTH-1];
    a_mag   = a_neg ? -i_rs1_data : i_rs1_data;
    b_mag   = b_neg ? -i_rs2_data : i_rs2_data;
    // Compare rather than borrow so a zero divisor yields all-ones quotient, dividend remainder
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_ge  = rem_sh >= {1'b0, dvsr_q};
    rem_sub = rem_sh[WIDTH-1:0] - dvsr_q;

    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvsr_d   = dvsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;
    hold_d   = hold_q;
    if (i_flush) begin
      cnt_d = '0;
    end else if (en) begin
      case (state_q)
        StIdle: if (div_issue) begin
          cnt_d    = '0;
          quo_d    = a_mag;
          rem_d    = '0;
          dvsr_d   = b_mag;
          q_neg_d  = (a_neg ^ b_neg) & (i_rs2_data != '0);
          r_neg_d  = a_neg;
          is_rem_d = i_funct3[1];
          hold_d   = {i_pc_plus_4, i_rs2_data, i_rd_addr, i_funct3, i_wb_sel,
                      i_reg_write_en, i_mem_write_en, i_mem_read_en};
        end
        StBusy: begin
          cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvsr_q   <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
      hold_q   <= '0;
    end else if (en | i_flush) begin
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvsr_q   <= dvsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
      hold_q   <= hold_d;
    end
  end

  assign div_res  = is_rem_q ? (r_neg_q ? -rem_q : rem_q) : (q_neg_q ? -quo_q : quo_q);
  assign hold_ctl = hold_q;
`else
  assign o_busy   = 1'b0;
  assign div_done = 1'b0;
  assign div_res  = '0;
  assign mul_res  = '0;
  assign hold_ctl = '0;
`endif

  logic [WIDTH-1:0] res_q, res_d, st_q, st_d, pc4_q, pc4_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       wb_q, wb_d;
  logic             rw_q, rw_d, mw_q, mw_d, mr_q, mr_d;

  always_comb begin
    res_d = '0;
    st_d  = '0;
    pc4_d = '0;
    rd_d  = '0;
    f3_d  = '0;
    wb_d  = '0;
    rw_d  = 1'b0;
    mw_d  = 1'b0;
    mr_d  = 1'b0;
    if (!(i_flush || o_busy)) begin
      if (div_done) begin
        {pc4_d, st_d, rd_d, f3_d, wb_d, rw_d, mw_d, mr_d} = hold_ctl;
        res_d = div_res;
      end else begin
        res_d = i_do_jump ? i_pc_plus_4 : (i_is_muldiv ? mul_res : alu_res);
        st_d  = i_rs2_data;
        pc4_d = i_pc_plus_4;
        rd_d  = i_rd_addr;
        f3_d  = i_funct3;
        wb_d  = i_wb_sel;
        rw_d  = i_reg_write_en;
        mw_d  = i_mem_write_en;
        mr_d  = i_mem_read_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      st_q  <= '0;
      pc4_q <= '0;
      rd_q  <= '0;
      f3_q  <= '0;
      wb_q  <= '0;
      rw_q  <= 1'b0;
      mw_q  <= 1'b0;
      mr_q  <= 1'b0;
    end else if (en | i_flush) begin
      res_q <= res_d;
      st_q  <= st_d;
      pc4_q <= pc4_d;
      rd_q  <= rd_d;
      f3_q  <= f3_d;
      wb_q  <= wb_d;
      rw_q  <= rw_d;
      mw_q  <= mw_d;
      mr_q  <= mr_d;
    end
  end

  assign o_result       = res_q;
  assign o_store_data   = st_q;
  assign o_pc_plus_4    = pc4_q;
  assign o_rd_addr      = rd_q;
  assign o_funct3       = f3_q;
  assign o_wb_sel       = wb_q;
  assign o_reg_write_en = rw_q;
  assign o_mem_write_en = mw_q;
  assign o_mem_read_en  = mr_q;

endmodule

// File: tb/tb_p_ex_mem_stage.sv
// Self-checking bench for p_ex_mem_stage: directed cases plus random ALU/branch/MUL/DIV traffic.
module tb_p_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, en, i_flush;
  logic        i_reg_write_en, i_mem_write_en, i_mem_read_en, i_alu_src_a, i_do_branch, i_do_jump;
  logic [1:0]  i_wb_sel, i_alu_src_b;
  logic        i_is_muldiv;
  logic [31:0] i_pc, i_pc_plus_4, i_rs1_data, i_rs2_data, i_imm;
  logic [4:0]  i_rd_addr;
  logic [2:0]  i_funct3;
  logic [6:0]  i_opcode;
  logic [3:0]  i_alu_op;
  logic        o_busy, o_branch_taken;
  logic [31:0] o_branch_target, o_result, o_store_data, o_pc_plus_4;
  logic [4:0]  o_rd_addr;
  logic [2:0]  o_funct3;
  logic [1:0]  o_wb_sel;
  logic        o_reg_write_en, o_mem_write_en, o_mem_read_en;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_res, exp_st, exp_pc4;
  logic [12:0] exp_ctl;

  p_ex_mem_stage dut (
    .clk(clk), .rst(rst), .en(en), .i_flush(i_flush),
    .i_reg_write_en(i_reg_write_en), .i_mem_write_en(i_mem_write_en),
    .i_mem_read_en(i_mem_read_en), .i_alu_src_a(i_alu_src_a), .i_do_branch(i_do_branch),
    .i_do_jump(i_do_jump), .i_wb_sel(i_wb_sel), .i_alu_src_b(i_alu_src_b),
    .i_is_muldiv(i_is_muldiv), .i_pc(i_pc), .i_pc_plus_4(i_pc_plus_4),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_rd_addr(i_rd_addr),
    .i_funct3(i_funct3), .i_opcode(i_opcode), .i_alu_op(i_alu_op), .o_busy(o_busy),
    .o_branch_taken(o_branch_taken), .o_branch_target(o_branch_target), .o_result(o_result),
    .o_store_data(o_store_data), .o_pc_plus_4(o_pc_plus_4), .o_rd_addr(o_rd_addr),
    .o_funct3(o_funct3), .o_wb_sel(o_wb_sel), .o_reg_write_en(o_reg_write_en),
    .o_mem_write_en(o_mem_write_en), .o_mem_read_en(o_mem_read_en)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh = b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << sh;
      4'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: return (a < b) ? 32'd1 : 32'd0;
      4'd5: return a ^ b;
      4'd6: return a >> sh;
      4'd7: return $signed(a) >>> sh;
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mul_ref(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint xa, xb;
    logic [63:0] p;
    xa = (f3[1:0] == 2'b11) ? longint'({32'h0, a}) : longint'($signed(a));
    xb = (f3[1:0] == 2'b01) ? longint'($signed(b)) : longint'({32'h0, b});
    p  = xa * xb;
    return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] div_ref(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : a;
    if (f3[0]) return f3[1] ? (a % b) : (a / b);
    return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic set_nop();
    {i_reg_write_en, i_mem_write_en, i_mem_read_en, i_alu_src_a, i_do_branch, i_do_jump} = '0;
    i_wb_sel = '0; i_alu_src_b = '0; i_is_muldiv = 1'b0;
    i_pc = '0; i_pc_plus_4 = '0; i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
    i_rd_addr = '0; i_funct3 = '0; i_opcode = 7'h33; i_alu_op = '0;
  endtask

  // Expected EX/MEM contents after the coming edge, from the current (non-divide) inputs
  task automatic predict();
    logic [31:0] a, b, r;
    if (i_flush) begin
      exp_res = '0; exp_st = '0; exp_pc4 = '0; exp_ctl = '0;
    end else if (en) begin
      a = i_alu_src_a ? i_pc : i_rs1_data;
      b = (i_alu_src_b == 2'b00) ? i_rs2_data : (i_alu_src_b == 2'b10) ? 32'd4 : i_imm;
      if (i_do_jump) r = i_pc_plus_4;
      else if (i_is_muldiv) begin
`ifdef RV32M_EXT_EN
        r = mul_ref(i_funct3, i_rs1_data, i_rs2_data);
`else
        r = 32'd0;
`endif
      end else r = alu_ref(i_alu_op, a, b);
      exp_res = r; exp_st = i_rs2_data; exp_pc4 = i_pc_plus_4;
      exp_ctl = {i_rd_addr, i_funct3, i_wb_sel, i_reg_write_en, i_mem_write_en, i_mem_read_en};
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_res"}, o_result, exp_res);
    check_eq({tag, "_st"}, o_store_data, exp_st);
    check_eq({tag, "_pc4"}, o_pc_plus_4, exp_pc4);
    check_eq({tag, "_ctl"}, {19'd0, o_rd_addr, o_funct3, o_wb_sel, o_reg_write_en,
                             o_mem_write_en, o_mem_read_en}, {19'd0, exp_ctl});
  endtask

  task automatic step_and_check(input string tag);
    predict();
    @(posedge clk); #1;
    check_regs(tag);
  endtask

  task automatic set_add(input logic [31:0] a, input logic [31:0] b);
    set_nop();
    i_rs1_data = a; i_rs2_data = b; i_reg_write_en = 1'b1; i_rd_addr = 5'd5;
  endtask

`ifdef RV32M_EXT_EN
  task automatic set_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    set_nop();
    i_is_muldiv = 1'b1; i_funct3 = f3; i_rs1_data = a; i_rs2_data = b;
    i_rd_addr = 5'($urandom_range(1, 31)); i_reg_write_en = 1'b1; i_pc_plus_4 = $urandom;
  endtask

  task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input bit stall);
    int busy_cnt = 0;
    int guard = 0;
    bit bubble_ok = 1'b1;
    logic [4:0] rd;
    set_div(f3, a, b);
    rd = i_rd_addr;
    en = 1'b1; i_flush = 1'b0;
    #1;
    while (o_busy && guard < 300) begin
      if (en) busy_cnt++;
      @(posedge clk); #1;
      guard++;
      if (o_reg_write_en !== 1'b0) bubble_ok = 1'b0;
      en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    en = 1'b1;
    check_eq({tag, "_busy_cycles"}, busy_cnt, 33);
    check_eq({tag, "_bubble"}, {31'd0, bubble_ok}, 32'd1);
    @(posedge clk); #1;
    check_eq({tag, "_res"}, o_result, div_ref(f3, a, b));
    check_eq({tag, "_rd_rw"}, {26'd0, o_rd_addr, o_reg_write_en}, {26'd0, rd, 1'b1});
    set_nop();
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; i_flush = 1'b0;
    set_nop();
    #1;
    check_eq("reset_regs", {o_result | o_store_data | o_pc_plus_4}, 32'd0);
    check_eq("reset_ctl", {19'd0, o_rd_addr, o_funct3, o_wb_sel, o_reg_write_en,
                           o_mem_write_en, o_mem_read_en}, 32'd0);
    check_eq("reset_busy", {31'd0, o_busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;

    set_add(32'd5, 32'd7);
    @(posedge clk); #1;
    check_eq("add_res", o_result, 32'd12);
    check_eq("add_rw", {31'd0, o_reg_write_en}, 32'd1);

    set_nop();
    i_do_branch = 1'b1; i_funct3 = 3'b000; i_rs1_data = 32'd3; i_rs2_data = 32'd3;
    i_pc = 32'h100; i_imm = 32'h20; i_opcode = 7'h63;
    #1;
    check_eq("beq_taken", {31'd0, o_branch_taken}, 32'd1);
    check_eq("beq_target", o_branch_target, 32'h120);
    en = 1'b0; #1;
    check_eq("beq_taken_en0", {31'd0, o_branch_taken}, 32'd0);
    en = 1'b1;
    set_nop();
    i_do_jump = 1'b1; i_opcode = 7'h67; i_rs1_data = 32'h203; i_imm = 32'd0;
    #1;
    check_eq("jalr_target", o_branch_target, 32'h202);
    check_eq("jalr_taken", {31'd0, o_branch_taken}, 32'd1);

    set_nop();
    i_is_muldiv = 1'b1; i_funct3 = 3'b001; i_rs1_data = 32'hFFFF_FFFF;
    i_rs2_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check_eq("mulh_ff", o_result, 32'd0);
    i_funct3 = 3'b011;
    @(posedge clk); #1;
`ifdef RV32M_EXT_EN
    check_eq("mulhu_ff", o_result, 32'hFFFF_FFFE);
`else
    check_eq("mulhu_off", o_result, 32'd0);
    i_funct3 = 3'b100; i_rs1_data = 32'hFFFF_FFF9; i_rs2_data = 32'd2; i_reg_write_en = 1'b1;
    #1;
    check_eq("div_off_busy", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("div_off_res", o_result, 32'd0);
    check_eq("div_off_rw", {31'd0, o_reg_write_en}, 32'd1);
`endif

    set_nop();
    @(posedge clk); #1;
    exp_res = '0; exp_st = '0; exp_pc4 = '0; exp_ctl = '0;
    for (int i = 0; i < 300; i++) begin
      i_alu_op = 4'($urandom_range(0, 9));
      i_alu_src_a = 1'($urandom); i_alu_src_b = 2'($urandom);
      i_rs1_data = $urandom;
      i_rs2_data = ($urandom_range(0, 3) == 0) ? i_rs1_data : $urandom;
      i_imm = $urandom; i_pc = $urandom; i_pc_plus_4 = i_pc + 32'd4;
      i_do_branch = ($urandom_range(0, 2) == 0); i_do_jump = ($urandom_range(0, 5) == 0);
      i_funct3 = 3'($urandom); i_opcode = ($urandom_range(0, 1) == 0) ? 7'h67 : 7'h63;
      i_rd_addr = 5'($urandom); i_wb_sel = 2'($urandom);
      {i_reg_write_en, i_mem_write_en, i_mem_read_en} = 3'($urandom);
      i_is_muldiv = !i_do_jump && !i_do_branch && ($urandom_range(0, 3) == 0);
`ifdef RV32M_EXT_EN
      if (i_is_muldiv) i_funct3[2] = 1'b0;
`endif
      en = ($urandom_range(0, 7) != 0); i_flush = ($urandom_range(0, 15) == 0);
      #1;
      check_eq("rnd_taken", {31'd0, o_branch_taken},
               {31'd0, ((i_do_branch && br_ref(i_funct3, i_rs1_data, i_rs2_data)) || i_do_jump)
                       && en && !i_flush});
      check_eq("rnd_target", o_branch_target,
               (i_opcode == 7'h67) ? ((i_rs1_data + i_imm) & 32'hFFFF_FFFE) : (i_pc + i_imm));
      step_and_check("rnd");
    end
    en = 1'b1; i_flush = 1'b0;
    set_nop();

`ifdef RV32M_EXT_EN
    run_div("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div_m7_2_const", o_result, 32'hFFFF_FFFD);
    run_div("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("rem_m7_2_const", o_result, 32'hFFFF_FFFF);
    run_div("divu_5_0", 3'b101, 32'd5, 32'd0, 1'b0);
    check_eq("divu_5_0_const", o_result, 32'hFFFF_FFFF);
    run_div("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_eq("div_ovf_const", o_result, 32'h8000_0000);
    run_div("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div("remu_5_0", 3'b111, 32'd5, 32'd0, 1'b0);
    run_div("div_m7_0", 3'b100, 32'hFFFF_FFF9, 32'd0, 1'b0);
    run_div("rem_m7_0", 3'b110, 32'hFFFF_FFF9, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i % 4 == 3) ? 32'd0 : (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 100));
      run_div("div_rnd", 3'($urandom_range(4, 7)), a, b, 1'b1);
    end

    set_div(3'b100, 32'd100, 32'd3);
    repeat (11) @(posedge clk);
    #1 i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    set_nop();
    #1;
    check_eq("flush_busy", {31'd0, o_busy}, 32'd0);
    check_eq("flush_bubble", {31'd0, o_reg_write_en}, 32'd0);
    check_eq("flush_res", o_result, 32'd0);
    set_add(32'd2, 32'd3);
    @(posedge clk); #1;
    check_eq("post_flush_add", o_result, 32'd5);

    set_div(3'b100, 32'd100, 32'd3);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    set_nop();
    #1;
    check_eq("rst_mid_div_busy", {31'd0, o_busy}, 32'd0);
    check_eq("rst_mid_div_rw", {31'd0, o_reg_write_en}, 32'd0);
    #2 rst = 1'b0;
`endif

    set_add(32'd40, 32'd2);
    @(posedge clk); #1;
    check_eq("pre_rst_add", o_result, 32'd42);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_res", o_result, 32'd0);
    check_eq("async_rst_rw", {31'd0, o_reg_write_en}, 32'd0);
    #2 rst = 1'b0;
    set_add(32'd1, 32'd1);
    @(posedge clk); #1;
    check_eq("post_rst_add", o_result, 32'd2);
    set_nop();
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("post_rst_idle", {o_result[30:0], o_reg_write_en}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/p_ex_mem_stage.md
Name: p_ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the RV32IM pipeline; consumes the ID/EX register outputs (controls, pc, pc+4, rs1/rs2 data, imm, rd, funct3, alu_op).
- Computes ALU, branch/jump resolution and M-extension results.
- Divide is iterative and stalls upstream via o_busy; results, store data and forwarded controls are registered for the MEM stage.

Parameters:
- WIDTH, 32, datapath width.
- DIV_CYCLES, 32, radix-2 divider iterations; must equal WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  pipeline advance; 0 holds EX/MEM registers and divider FSM
- i_flush  in  1  load bubble into EX/MEM; abort divide
- i_reg_write_en, i_mem_write_en, i_mem_read_en, i_alu_src_a, i_do_branch, i_do_jump  in  1 each  ID/EX controls
- i_wb_sel, i_alu_src_b  in  2 each  ID/EX controls
- i_is_muldiv  in  1  instruction is an M-extension op; funct3 selects the op
- i_pc, i_pc_plus_4, i_rs1_data, i_rs2_data, i_imm  in  WIDTH each  ID/EX data
- i_rd_addr  in  5;  i_funct3  in  3;  i_opcode  in  7;  i_alu_op  in  ALU_OP_WIDTH
- o_busy  out  1  divider occupying stage; upstream must hold
- o_branch_taken  out  1  combinational redirect to IF
- o_branch_target  out  WIDTH  combinational redirect address
- o_result, o_store_data, o_pc_plus_4  out  WIDTH each  EX/MEM registers
- o_rd_addr  out  5;  o_funct3  out  3;  o_wb_sel  out  2
- o_reg_write_en, o_mem_write_en, o_mem_read_en  out  1 each  EX/MEM registers

Behaviour:
- Reset: every registered output is 0, FSM is IDLE, iteration counter is 0. Asserting reset mid-divide aborts the divide.
- Operand A = i_alu_src_a ? i_pc : i_rs1_data.
- Operand B selected by i_alu_src_b: 00 rs2, 01 imm, 10 constant 4, 11 imm.
- ALU ops (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND) use the ALU_OP encodings of rv32i_decoder_header.vh. Shift amount = B[4:0].
- Branch compare on rs1/rs2 by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
- o_branch_taken = ((i_do_branch & cond) | i_do_jump) & en & ~i_flush & ~o_busy.
- Branch target:
  - JALR (opcode 1100111): (rs1 + imm) & ~1.
  - Otherwise: pc + imm.
- Jumps write o_result = pc+4 via wb_sel; the stage passes all controls through unchanged.
- MUL family (i_is_muldiv, funct3[2]=0) completes in a single cycle, using the full 64-bit product:
  - 000: low 32 bits.
  - 001: high 32 bits, signed×signed.
  - 010: high 32 bits, signed×unsigned.
  - 011: high 32 bits, unsigned×unsigned.
- Divider FSM IDLE -> BUSY -> DONE -> IDLE:
  - Issue: in IDLE with en=1 and i_is_muldiv & funct3[2]=1, o_busy=1 combinationally, operand magnitudes and signs are latched, go to BUSY, EX/MEM loads a bubble.
  - BUSY: one restoring iteration per enabled cycle; counter runs 0..DIV_CYCLES-1; o_busy=1; EX/MEM loads a bubble each cycle. After the last iteration, go to DONE.
  - DONE: o_busy=0; EX/MEM loads the sign-corrected result with the held instruction's controls; go to IDLE.
  - o_busy is high for exactly DIV_CYCLES+1 cycles; total latency is DIV_CYCLES+2 cycles.
- Divider funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- Special cases keep the full latency.
- en=0 freezes the FSM, counter and registers; o_busy holds its value.
- i_flush (highest priority after reset): EX/MEM loads a bubble (all controls 0, data 0) and the FSM returns to IDLE the same edge.
- Bubble = reg_write/mem_write/mem_read = 0. Store data = i_rs2_data.

Optional Feature:
- Macro: RV32M_EXT_EN.
- Defined: MUL/DIV behaviour as above.
- Undefined: multiplier and divider are not built; i_is_muldiv instructions write o_result = 0 and o_busy is tied 0.

Test Plan:
- ADD rs1=5, rs2=7, alu_src_b=00 -> next edge o_result=12, o_reg_write_en=1.
- BEQ rs1=rs2=3, pc=0x100, imm=0x20 -> o_branch_taken=1, o_branch_target=0x120. JALR rs1=0x203, imm=0 -> target 0x202.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> o_result=0 after 1 cycle. MULHU same operands -> 0xFFFFFFFE.
- DIV −7/2 -> o_busy high 33 cycles; result −3 in EX/MEM on DONE edge. REM −7/2 -> −1. DIVU 5/0 -> 0xFFFFFFFF. DIV 0x80000000/−1 -> 0x80000000.
- i_flush at BUSY cycle 10 -> FSM returns to IDLE, o_busy=0 next cycle, EX/MEM holds a bubble.
- rst asserted mid-divide (async, between edges) -> all outputs 0 immediately; after release, ADD 1+1 gives 2.
